// File: rtl/deconv_col_feeder.sv
// Column sequencer feeding the per-column deconvolution engine: K weight columns per input column.
// Optional build macro DECONV_FEEDER_PREFETCH_EN overlaps the next column fetch with the last weight beat.
module deconv_col_feeder #(
  parameter int BIT_WIDTH            = 8,
  parameter int NO_COL_KERNEL        = 5,
  parameter int NO_COL_INPUT_FEATURE = 8,
  parameter int NO_IP_COLS           = 8
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_w_wr_en,
  input  logic [2:0]                                i_w_wr_addr,
  input  logic [BIT_WIDTH*NO_COL_KERNEL-1:0]        i_w_wr_data,
  input  logic                                      i_start,
  input  logic                                      i_ip_valid,
  input  logic [BIT_WIDTH*NO_COL_INPUT_FEATURE-1:0] i_ip_data,
  output logic                                      o_ip_ready,
  input  logic                                      i_pe_ready,
  output logic [BIT_WIDTH*NO_COL_KERNEL-1:0]        o_weight_col,
  output logic [BIT_WIDTH*NO_COL_INPUT_FEATURE-1:0] o_feature_map_col,
  output logic                                      o_enable_loadw,
  output logic                                      o_enable_loadip,
  output logic [2:0]                                o_kernel_column_id,
  output logic [3:0]                                o_input_column_id,
  output logic                                      o_en_fifo_loop,
  output logic                                      o_en_prcs_new_chnl,
  output logic                                      o_busy,
  output logic                                      o_done
);

  localparam int         WW      = BIT_WIDTH * NO_COL_KERNEL;
  localparam logic [2:0] KC_LAST = 3'(NO_COL_KERNEL - 1);
  localparam logic [3:0] IC_LAST = 4'(NO_IP_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [2:0]    kc_r;
  logic [3:0]    ic_r;
  logic          ip_ready_r;
  logic [WW-1:0] wreg_r [NO_COL_KERNEL];

  logic       xfer_s;
  logic       take_s;
  logic [2:0] adv_kc_s;
  logic [3:0] adv_ic_s;
  logic [2:0] beat_kc_s;
  logic [3:0] beat_ic_s;
  logic       beat_loop_s;
  logic       beat_last_s;
  logic       beat_pref_s;

  // Transfer qualification and the counters of the beat that will be presented next.
  always_comb begin
    xfer_s = o_enable_loadw & i_pe_ready;
`ifdef DECONV_FEEDER_PREFETCH_EN
    // A prefetch handshake is only offered when the current beat also leaves.
    o_ip_ready = ip_ready_r & ((state_r != S_ISSUE) | i_pe_ready);
`else
    o_ip_ready = ip_ready_r;
`endif
    take_s = o_ip_ready & i_ip_valid;
    if (kc_r == KC_LAST) begin
      adv_kc_s = 3'd0;
      adv_ic_s = ic_r + 4'd1;
    end else begin
      adv_kc_s = kc_r + 3'd1;
      adv_ic_s = ic_r;
    end
    if (state_r == S_ISSUE) begin
      beat_kc_s = adv_kc_s;
      beat_ic_s = adv_ic_s;
    end else begin
      beat_kc_s = kc_r;
      beat_ic_s = ic_r;
    end
    beat_loop_s = (beat_kc_s == KC_LAST);
    beat_last_s = beat_loop_s & (beat_ic_s == IC_LAST);
`ifdef DECONV_FEEDER_PREFETCH_EN
    beat_pref_s = beat_loop_s & (beat_ic_s != IC_LAST);
`else
    beat_pref_s = 1'b0;
`endif
  end

  // Weight register file; loaded only while idle and deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_w_wr_en && (state_r == S_IDLE) && ({29'd0, i_w_wr_addr} < 32'(NO_COL_KERNEL))) begin
      wreg_r[i_w_wr_addr] <= i_w_wr_data;
    end
  end

  // Sequencer FSM with all engine-side outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r            <= S_IDLE;
      kc_r               <= 3'd0;
      ic_r               <= 4'd0;
      ip_ready_r         <= 1'b0;
      o_weight_col       <= '0;
      o_feature_map_col  <= '0;
      o_enable_loadw     <= 1'b0;
      o_enable_loadip    <= 1'b0;
      o_kernel_column_id <= 3'd0;
      o_input_column_id  <= 4'd0;
      o_en_fifo_loop     <= 1'b0;
      o_en_prcs_new_chnl <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state_r    <= S_FETCH;
            kc_r       <= 3'd0;
            ic_r       <= 4'd0;
            o_busy     <= 1'b1;
            ip_ready_r <= 1'b1;
          end
        end
        S_FETCH: begin
          if (take_s) begin
            state_r            <= S_ISSUE;
            o_feature_map_col  <= i_ip_data;
            o_weight_col       <= wreg_r[beat_kc_s];
            o_kernel_column_id <= beat_kc_s;
            o_input_column_id  <= beat_ic_s;
            o_enable_loadw     <= 1'b1;
            o_enable_loadip    <= (beat_kc_s == 3'd0);
            o_en_fifo_loop     <= beat_loop_s;
            o_en_prcs_new_chnl <= beat_last_s;
            ip_ready_r         <= beat_pref_s;
          end
        end
        S_ISSUE: begin
          if (xfer_s) begin
            kc_r <= adv_kc_s;
            ic_r <= adv_ic_s;
            if ((kc_r != KC_LAST) || take_s) begin
              if (take_s) begin
                o_feature_map_col <= i_ip_data;
              end
              o_weight_col       <= wreg_r[beat_kc_s];
              o_kernel_column_id <= beat_kc_s;
              o_input_column_id  <= beat_ic_s;
              o_enable_loadip    <= (beat_kc_s == 3'd0);
              o_en_fifo_loop     <= beat_loop_s;
              o_en_prcs_new_chnl <= beat_last_s;
              ip_ready_r         <= beat_pref_s;
            end else if (ic_r != IC_LAST) begin
              // Next column not on hand: bubble through FETCH.
              state_r            <= S_FETCH;
              o_enable_loadw     <= 1'b0;
              o_enable_loadip    <= 1'b0;
              o_en_fifo_loop     <= 1'b0;
              o_en_prcs_new_chnl <= 1'b0;
              ip_ready_r         <= 1'b1;
            end else begin
              state_r            <= S_DONE;
              ip_ready_r         <= 1'b0;
              o_weight_col       <= '0;
              o_feature_map_col  <= '0;
              o_enable_loadw     <= 1'b0;
              o_enable_loadip    <= 1'b0;
              o_kernel_column_id <= 3'd0;
              o_input_column_id  <= 4'd0;
              o_en_fifo_loop     <= 1'b0;
              o_en_prcs_new_chnl <= 1'b0;
              o_busy             <= 1'b0;
              o_done             <= 1'b1;
            end
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deconv_col_feeder.sv
// Self-checking bench for deconv_col_feeder: table of run scenarios plus a beat scoreboard.
module tb_deconv_col_feeder;

  localparam int K   = 5;
  localparam int NIP = 8;
`ifdef DECONV_FEEDER_PREFETCH_EN
  localparam int BASE = 41;
`else
  localparam int BASE = 48;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_w_wr_en;
  logic [2:0]  i_w_wr_addr;
  logic [39:0] i_w_wr_data;
  logic        i_start;
  logic        i_ip_valid;
  logic [63:0] i_ip_data;
  logic        o_ip_ready;
  logic        i_pe_ready;
  logic [39:0] o_weight_col;
  logic [63:0] o_feature_map_col;
  logic        o_enable_loadw;
  logic        o_enable_loadip;
  logic [2:0]  o_kernel_column_id;
  logic [3:0]  o_input_column_id;
  logic        o_en_fifo_loop;
  logic        o_en_prcs_new_chnl;
  logic        o_busy;
  logic        o_done;

  deconv_col_feeder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_w_wr_en(i_w_wr_en), .i_w_wr_addr(i_w_wr_addr), .i_w_wr_data(i_w_wr_data),
    .i_start(i_start), .i_ip_valid(i_ip_valid), .i_ip_data(i_ip_data), .o_ip_ready(o_ip_ready),
    .i_pe_ready(i_pe_ready), .o_weight_col(o_weight_col), .o_feature_map_col(o_feature_map_col),
    .o_enable_loadw(o_enable_loadw), .o_enable_loadip(o_enable_loadip),
    .o_kernel_column_id(o_kernel_column_id), .o_input_column_id(o_input_column_id),
    .o_en_fifo_loop(o_en_fifo_loop), .o_en_prcs_new_chnl(o_en_prcs_new_chnl),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [39:0] w;
    logic [63:0] fm;
    logic [2:0]  kc;
    logic [3:0]  ic;
    logic        loadip;
    logic        loop;
    logic        chnl;
  } beat_t;

  typedef struct {
    int stall_kc; int stall_ic; int stall_len;
    int gap_col;  int gap_len;
    bit wr_busy;  bit start_mid;
    int exp_beats; int exp_busy;
  } vec_t;

  beat_t       q[$];
  logic [39:0] wexp [K];
  vec_t        vecs [6];
  vec_t        cur;
  int          total = 0;
  int          bad   = 0;
  int          phase;   // 0 idle, 1 busy, 2 done
  int          next_col, stall_cnt, gap_cnt, beats, busy_cyc, done_cnt;
  bit          poked, start_req, wr_req, rst_hit;
  logic [2:0]  wr_addr;
  logic [39:0] wr_data;

  function automatic logic [63:0] col_data(input int n);
    return 64'(n) * 64'h0101_0101_0101_0101 + 64'h0807_0605_0403_0201;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    beat_t act;
    beat_t b;
    bit    stall, xfer, last, exp_busy, exp_loadw, exp_ipr;
    @(negedge i_clk);
    i_start     = start_req;
    start_req   = 1'b0;
    i_w_wr_en   = wr_req;
    i_w_wr_addr = wr_addr;
    i_w_wr_data = wr_data;
    wr_req      = 1'b0;
    if (q.size() > 0 && q[0].ic == 4'd1 && q[0].kc == 3'd0 && !poked) begin
      poked = 1'b1;
      if (cur.start_mid) i_start = 1'b1;
      if (cur.wr_busy) begin
        i_w_wr_en   = 1'b1;
        i_w_wr_addr = 3'd2;
        i_w_wr_data = {5{8'hFF}};
      end
    end
    stall = (q.size() > 0) && (q[0].kc == 3'(cur.stall_kc)) && (q[0].ic == 4'(cur.stall_ic))
            && (stall_cnt < cur.stall_len);
    i_pe_ready = !stall;
    if (stall) stall_cnt++;
    i_ip_valid = (next_col < NIP) && !(next_col == cur.gap_col && gap_cnt < cur.gap_len);
    i_ip_data  = col_data(next_col);
    #1;
    if (o_ip_ready && !i_ip_valid && next_col == cur.gap_col) gap_cnt++;

    exp_busy  = (phase == 1);
    exp_loadw = exp_busy && (q.size() > 0);
`ifdef DECONV_FEEDER_PREFETCH_EN
    exp_ipr = exp_busy && ((q.size() == 0) || (q.size() == 1 && q[0].ic != 4'd7 && i_pe_ready));
`else
    exp_ipr = exp_busy && (q.size() == 0);
`endif
    chk("ctl busy/done/loadw/ipready", 128'({o_busy, o_done, o_enable_loadw, o_ip_ready}),
        128'({exp_busy, phase == 2, exp_loadw, exp_ipr}));

    act = {o_weight_col, o_feature_map_col, o_kernel_column_id, o_input_column_id,
           o_enable_loadip, o_en_fifo_loop, o_en_prcs_new_chnl};
    if (o_enable_loadw && q.size() > 0) chk("beat", 128'(act), 128'(q[0]));
    if (phase != 1) chk("idle_zero", 128'({act, o_enable_loadw}), 128'd0);
    if (o_busy) busy_cyc++;
    if (o_done) done_cnt++;

    xfer = o_enable_loadw && i_pe_ready && (q.size() > 0);
    last = 1'b0;
    if (xfer) begin
      b    = q.pop_front();
      last = b.chnl;
      beats++;
    end
    if (o_ip_ready && i_ip_valid && next_col < NIP) begin
      for (int k = 0; k < K; k++) begin
        b.w      = wexp[k];
        b.fm     = col_data(next_col);
        b.kc     = 3'(k);
        b.ic     = 4'(next_col);
        b.loadip = (k == 0);
        b.loop   = (k == K - 1);
        b.chnl   = (k == K - 1) && (next_col == NIP - 1);
        q.push_back(b);
      end
      next_col++;
    end
    if (i_w_wr_en && phase == 0 && int'(i_w_wr_addr) < K) wexp[i_w_wr_addr] = i_w_wr_data;
    case (phase)
      0:       if (i_start) phase = 1;
      1:       if (xfer && last) phase = 2;
      default: phase = 0;
    endcase
  endtask

  task automatic run_seq(input vec_t v, input bit rst_mid);
    cur = v;
    q.delete();
    next_col = 0; stall_cnt = 0; gap_cnt = 0; beats = 0; busy_cyc = 0; done_cnt = 0;
    poked = 1'b0; rst_hit = 1'b0; start_req = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (phase == 0 && done_cnt > 0) break;
      if (rst_mid && q.size() > 0 && q[0].kc == 3'd3 && q[0].ic == 4'd4) begin
        rst_hit = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 128'({o_weight_col, o_feature_map_col, o_enable_loadw,
            o_enable_loadip, o_kernel_column_id, o_input_column_id, o_en_fifo_loop,
            o_en_prcs_new_chnl, o_busy, o_done, o_ip_ready}), 128'd0);
        q.delete();
        phase = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        break;
      end
    end
    if (rst_mid) begin
      chk("reset_point_reached", 128'(rst_hit), 128'd1);
    end else begin
      chk("beat_count", 128'(beats), 128'(v.exp_beats));
      chk("busy_cycles", 128'(busy_cyc), 128'(v.exp_busy));
      chk("done_pulses", 128'(done_cnt), 128'd1);
    end
  endtask

  initial begin
    vecs[0] = '{stall_kc:0, stall_ic:0, stall_len:0, gap_col:0, gap_len:0, wr_busy:0, start_mid:0,
                exp_beats:40, exp_busy:BASE};
    vecs[1] = '{stall_kc:2, stall_ic:1, stall_len:3, gap_col:0, gap_len:0, wr_busy:0, start_mid:0,
                exp_beats:40, exp_busy:BASE + 3};
    vecs[2] = '{stall_kc:0, stall_ic:0, stall_len:0, gap_col:3, gap_len:4, wr_busy:0, start_mid:0,
                exp_beats:40, exp_busy:BASE + 4};
    vecs[3] = '{stall_kc:0, stall_ic:0, stall_len:0, gap_col:0, gap_len:0, wr_busy:1, start_mid:0,
                exp_beats:40, exp_busy:BASE};
    vecs[4] = '{stall_kc:0, stall_ic:0, stall_len:0, gap_col:0, gap_len:0, wr_busy:0, start_mid:1,
                exp_beats:40, exp_busy:BASE};
    vecs[5] = '{stall_kc:4, stall_ic:2, stall_len:2, gap_col:5, gap_len:1, wr_busy:0, start_mid:0,
                exp_beats:40, exp_busy:BASE + 3};
    cur = vecs[0];
    i_rst_n = 1'b0; i_w_wr_en = 1'b0; i_w_wr_addr = 3'd0; i_w_wr_data = 40'd0;
    i_start = 1'b0; i_ip_valid = 1'b0; i_ip_data = 64'd0; i_pe_ready = 1'b0;
    phase = 0; start_req = 1'b0; wr_req = 1'b0; wr_addr = 3'd0; wr_data = 40'd0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("reset_state", 128'({o_weight_col, o_feature_map_col, o_enable_loadw, o_enable_loadip,
        o_kernel_column_id, o_input_column_id, o_en_fifo_loop, o_en_prcs_new_chnl,
        o_busy, o_done, o_ip_ready}), 128'd0);
    i_rst_n = 1'b1;

    for (int k = 0; k < K; k++) begin
      wr_req  = 1'b1;
      wr_addr = 3'(k);
      wr_data = {5{8'(17 * (k + 1))}};
      step();
    end

    for (int v = 0; v < 6; v++) begin
      run_seq(vecs[v], 1'b0);
      step();
    end

    // Out-of-range address in IDLE must leave the register file alone.
    wr_req = 1'b1; wr_addr = 3'd6; wr_data = {5{8'hA5}};
    step();

    run_seq(vecs[0], 1'b1);
    step();
    run_seq(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deconv_col_feeder.md
Name: deconv_col_feeder

Overview:
Column sequencer that drives the per-column deconvolution engine, which consumes one weight column and one input-feature column per beat. It holds the K kernel columns of one channel in a local register file. It pulls input-feature columns from an upstream valid/ready stream. For each input column it issues all K weight columns in order, and it generates the column ids, loop-back strobe and new-channel strobe that the engine expects.

Parameters:
BIT_WIDTH, 8, bits per element
NO_COL_KERNEL, 5, kernel columns K (column height also K elements)
NO_COL_INPUT_FEATURE, 8, elements per input-feature column
NO_IP_COLS, 8, input columns processed per start (max 16)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_w_wr_en  in  1  weight column write strobe
i_w_wr_addr  in  3  weight column index 0..K-1
i_w_wr_data  in  BIT_WIDTH*NO_COL_KERNEL  weight column data
i_start  in  1  one-cycle start pulse
i_ip_valid  in  1  upstream input column valid
i_ip_data  in  BIT_WIDTH*NO_COL_INPUT_FEATURE  upstream input column
o_ip_ready  out  1  accept upstream column
i_pe_ready  in  1  engine ready (engine o_ready)
o_weight_col  out  BIT_WIDTH*NO_COL_KERNEL  weight column to engine
o_feature_map_col  out  BIT_WIDTH*NO_COL_INPUT_FEATURE  input column to engine
o_enable_loadw  out  1  beat valid, weight column present
o_enable_loadip  out  1  new input column on this beat
o_kernel_column_id  out  3  current weight column id
o_input_column_id  out  4  current input column id
o_en_fifo_loop  out  1  last weight column of current input column
o_en_prcs_new_chnl  out  1  final beat of the channel
o_busy  out  1  sequence in progress
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM = IDLE; weight register file is not cleared.
- Weight writes are accepted only in IDLE. If i_w_wr_addr >= K, the write is ignored. Writes while o_busy=1 are ignored.
- FSM states: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - o_busy=0.
  - i_start=1 → FETCH next cycle; clear input col counter ic and kernel col counter kc.
- FETCH:
  - o_busy=1, o_ip_ready=1, o_enable_loadw=0.
  - On i_ip_valid: latch i_ip_data into o_feature_map_col → ISSUE next cycle with kc=0.
- ISSUE:
  - o_enable_loadw=1; o_weight_col = wreg[kc]; o_kernel_column_id=kc; o_input_column_id=ic.
  - o_enable_loadip=1 only when kc=0.
  - o_en_fifo_loop=1 when kc=K-1.
  - o_en_prcs_new_chnl=1 when kc=K-1 and ic=NO_IP_COLS-1.
- Transfer rule: a beat transfers when o_enable_loadw & i_pe_ready. While stalled, all engine-side outputs hold stable. All outputs are registered; the combinational path from i_pe_ready to outputs is limited to transfer qualification.
- On a transfer:
  - kc<K-1: kc++.
  - kc=K-1 and ic<NO_IP_COLS-1: kc=0, ic++, → FETCH.
  - kc=K-1 and ic=NO_IP_COLS-1: → DONE.
- DONE: o_done=1 for exactly one cycle; outputs clear to 0 → IDLE.
- i_start outside IDLE is ignored.
- Async reset mid-sequence: immediate return to IDLE with all outputs 0. The partially consumed column is lost, and upstream must restart.
- Throughput without the optional feature: K+1 cycles per input column, i.e. NO_IP_COLS*(K+1) cycles plus DONE when never stalled.

Optional Feature:
Macro: DECONV_FEEDER_PREFETCH_EN.
- Defined: during ISSUE, o_ip_ready=1 on the kc=K-1 beat when ic<NO_IP_COLS-1. If i_ip_valid and the beat transfers in the same cycle, the next column is latched and the FSM stays in ISSUE with kc=0, ic++ (no FETCH bubble). If valid is absent, the FSM falls back to FETCH.
- Undefined: o_ip_ready is asserted only in FETCH; one bubble cycle per input column.

Test Plan:
- Load weights 0x11..0x55 into cols 0..4; start; upstream always valid with columns ic*0x0101..; i_pe_ready=1 → 8×5=40 beats. kc sequence 0..4 repeating; ic 0..7. o_enable_loadip high on 8 beats, o_en_fifo_loop on 8 beats, o_en_prcs_new_chnl on beat 40 only. o_done follows one cycle later; total 48 beats+DONE without prefetch, 40 beats+1 FETCH with prefetch.
- Toggle i_pe_ready low for 3 cycles at kc=2, ic=1 → outputs held, no id skip, beat count still 40.
- Withhold i_ip_valid for 4 cycles at column 3 → FSM stays in FETCH, o_enable_loadw=0, resumes with ic=3 and kc=0.
- Write weight col 2 with 0xFF while busy → ignored; o_weight_col at kc=2 keeps the pre-start value. Write with addr 6 in IDLE → no change.
- Assert i_rst_n=0 at kc=3, ic=4 → all outputs 0 immediately. A new start after reset runs a full 40-beat sequence with the original weights.
- Pulse i_start during ISSUE → ignored; sequence length unchanged, single o_done.
